// File: rtl/obj_bank_pkg.sv
// Shared types and constants for the double-buffered object position bank.
package obj_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } commit_state_t;

  localparam logic [6:0] STATUS_OFF      = 7'h40;
  localparam logic [6:0] CTRL_OFF        = 7'h41;
  localparam int         N_OBJ_DEFAULT   = 8;
  localparam int         COORD_W_DEFAULT = 10;
  localparam int         FRAME_CNT_W     = 16;

endpackage

// File: rtl/obj_commit_fsm.sv
// Commit sequencer: vblank edge detect, IDLE/ARMED/COMMIT state, copy pointer and busy flag.
module obj_commit_fsm
  import obj_bank_pkg::*;
#(
  parameter int N_OBJ = N_OBJ_DEFAULT,
  parameter int IDX_W = $clog2(N_OBJ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vblank,
  input  logic             dirty,
  input  logic             force_req,
  output logic             copy_en,
  output logic [IDX_W-1:0] copy_idx,
  output logic             busy,
  output logic             commit_start
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  commit_state_t    state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic             busy_reg, busy_next;
  logic             vb_q_reg;
  logic             rise;

  assign rise = vblank && !vb_q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
      vb_q_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= busy_next;
      vb_q_reg  <= vblank;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    busy_next    = busy_reg;
    commit_start = 1'b0;
    case (state_reg)
      IDLE: begin
        // A rising vblank seen here is dropped on purpose: only ARMED reacts to it.
        if (force_req) begin
          commit_start = 1'b1;
        end else if (dirty) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (rise || force_req) begin
          commit_start = 1'b1;
        end
      end
      COMMIT: begin
        ptr_next = ptr_reg + IDX_W'(1);
        if (ptr_reg == LAST_IDX) begin
          state_next = dirty ? ARMED : IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (commit_start) begin
      state_next = COMMIT;
      ptr_next   = '0;
      busy_next  = 1'b1;
    end
  end

  assign copy_en  = (state_reg == COMMIT);
  assign copy_idx = ptr_reg;
  assign busy     = busy_reg;

endmodule

// File: rtl/obj_bank_arbiter.sv
// Shadow/live object position bank between the CPU bus and the renderer.
// Optional frame counter in STATUS[31:16] when OBJ_FRAME_COUNTER_EN is defined.
module obj_bank_arbiter
  import obj_bank_pkg::*;
#(
  parameter int N_OBJ   = N_OBJ_DEFAULT,
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int IDX_W   = $clog2(N_OBJ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_adr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  input  logic               vblank,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_ack,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);

  if (N_OBJ < 2 || N_OBJ > 32 || (N_OBJ & (N_OBJ - 1)) != 0) begin : g_bad_n_obj
    $error("obj_bank_arbiter: N_OBJ must be a power of two between 2 and 32");
  end

  // CPU address decode
  logic [6:0]       cpu_off;
  logic             entry_hit;
  logic [IDX_W-1:0] cpu_idx;
  logic             cpu_is_y;
  logic             store;
  logic             ctrl_force;
  logic             unused_bits;

  assign cpu_off     = cpu_adr[8:2];
  assign entry_hit   = (cpu_off < 7'(2 * N_OBJ));
  assign cpu_idx     = cpu_off[IDX_W:1];
  assign cpu_is_y    = cpu_off[0];
  assign store       = cpu_en && cpu_we && entry_hit;
  assign ctrl_force  = cpu_en && cpu_we && (cpu_off == CTRL_OFF) && cpu_wdata[0];
  assign unused_bits = ^{cpu_adr[31:9], cpu_adr[1:0], cpu_wdata[31:COORD_W]};

  // Commit sequencer
  logic             dirty_reg, dirty_next;
  logic             force_pend_reg, force_pend_next;
  logic             copy_en;
  logic [IDX_W-1:0] copy_idx;
  logic             commit_start;

  obj_commit_fsm #(
    .N_OBJ (N_OBJ),
    .IDX_W (IDX_W)
  ) u_commit_fsm (
    .clk          (clk),
    .reset        (reset),
    .vblank       (vblank),
    .dirty        (dirty_reg),
    .force_req    (ctrl_force || force_pend_reg),
    .copy_en      (copy_en),
    .copy_idx     (copy_idx),
    .busy         (busy),
    .commit_start (commit_start)
  );

  // A store landing on the commit-start edge keeps dirty set; that can only
  // cost one redundant commit, never a lost update.
  always_comb begin
    dirty_next = dirty_reg;
    if (store) begin
      dirty_next = 1'b1;
    end else if (commit_start) begin
      dirty_next = 1'b0;
    end
  end

  // A force written mid-commit is remembered and honoured once the FSM is idle again.
  always_comb begin
    force_pend_next = force_pend_reg || ctrl_force;
    if (commit_start) begin
      force_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_reg      <= 1'b0;
      force_pend_reg <= 1'b0;
    end else begin
      dirty_reg      <= dirty_next;
      force_pend_reg <= force_pend_next;
    end
  end

  // Shadow and live banks
  logic [COORD_W-1:0] shadow_x_reg [N_OBJ];
  logic [COORD_W-1:0] shadow_y_reg [N_OBJ];
  logic [COORD_W-1:0] live_x_reg   [N_OBJ];
  logic [COORD_W-1:0] live_y_reg   [N_OBJ];

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow_x_reg[gi] <= '0;
        shadow_y_reg[gi] <= '0;
        live_x_reg[gi]   <= '0;
        live_y_reg[gi]   <= '0;
      end else begin
        if (store && (cpu_idx == IDX_W'(gi))) begin
          if (cpu_is_y) begin
            shadow_y_reg[gi] <= cpu_wdata[COORD_W-1:0];
          end else begin
            shadow_x_reg[gi] <= cpu_wdata[COORD_W-1:0];
          end
        end
        // Copies the pre-edge shadow value, so a same-cycle store waits for the next commit.
        if (copy_en && (copy_idx == IDX_W'(gi))) begin
          live_x_reg[gi] <= shadow_x_reg[gi];
          live_y_reg[gi] <= shadow_y_reg[gi];
        end
      end
    end
  end

  // Frame counter
  logic [FRAME_CNT_W-1:0] frame_cnt;

`ifdef OBJ_FRAME_COUNTER_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (copy_en && (copy_idx == LAST_IDX)) begin
      frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_reg;
`else
  assign frame_cnt = '0;
`endif

  // CPU load path: shadow only, zero when not selected so it can be OR-ed upstream.
  always_comb begin
    cpu_rdata = '0;
    if (cpu_en) begin
      if (entry_hit) begin
        cpu_rdata = cpu_is_y ? 32'(shadow_y_reg[cpu_idx]) : 32'(shadow_x_reg[cpu_idx]);
      end else if (cpu_off == STATUS_OFF) begin
        cpu_rdata = {frame_cnt, 14'b0, dirty_reg, busy};
      end
    end
  end

  // Renderer port: one request is parked while the live bank is being rewritten.
  logic               rd_ack_reg;
  logic [COORD_W-1:0] rd_x_reg, rd_y_reg;
  logic               pend_reg;
  logic [IDX_W-1:0]   pend_idx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ack_reg   <= 1'b0;
      rd_x_reg     <= '0;
      rd_y_reg     <= '0;
      pend_reg     <= 1'b0;
      pend_idx_reg <= '0;
    end else begin
      rd_ack_reg <= 1'b0;
      if (busy) begin
        if (rd_req && !pend_reg) begin
          pend_reg     <= 1'b1;
          pend_idx_reg <= rd_idx;
        end
      end else if (pend_reg) begin
        rd_ack_reg <= 1'b1;
        rd_x_reg   <= live_x_reg[pend_idx_reg];
        rd_y_reg   <= live_y_reg[pend_idx_reg];
        pend_reg   <= 1'b0;
      end else if (rd_req) begin
        rd_ack_reg <= 1'b1;
        rd_x_reg   <= live_x_reg[rd_idx];
        rd_y_reg   <= live_y_reg[rd_idx];
      end
    end
  end

  assign rd_ack = rd_ack_reg;
  assign rd_x   = rd_x_reg;
  assign rd_y   = rd_y_reg;

endmodule

// File: tb/tb_obj_bank_arbiter.sv
// Directed bench for obj_bank_arbiter: table of CPU accesses plus commit/stall/reset sequences.
module tb_obj_bank_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        cpu_we;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        vblank;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic        rd_ack;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  obj_bank_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .cpu_we    (cpu_we),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .vblank    (vblank),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ack    (rd_ack),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        we;
    logic [6:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("check %s: got %h, expected %h, ok", name, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input logic b, input logic d);
`ifdef OBJ_FRAME_COUNTER_EN
    return {exp_frames[15:0], 14'b0, d, b};
`else
    return {16'b0, 14'b0, d, b};
`endif
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic cpu_write(input logic [6:0] off, input logic [31:0] d);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_adr = {23'b0, off, 2'b00}; cpu_wdata = d;
    @(negedge clk);
    cpu_en = 1'b0; cpu_we = 1'b0;
    $display("cpu write off=%h data=%h", off, d);
  endtask

  task automatic cpu_read(input logic [6:0] off, output logic [31:0] d);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_adr = {23'b0, off, 2'b00};
    #1 d = cpu_rdata;
    cpu_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic render_read(input int idx, output logic [9:0] x, output logic [9:0] y);
    rd_req = 1'b1; rd_idx = 3'(idx);
    @(negedge clk);
    rd_req = 1'b0;
    check($sformatf("rd_ack_idx%0d", idx), 32'(rd_ack), 32'd1);
    x = rd_x; y = rd_y;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic vblank_commit(output int cycles);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    wait_idle(cycles);
    vblank = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    logic [31:0] d;
    logic [9:0]  x, y, ack_x, ack_y;
    int          c, fall_k, ack_k, ack_cnt;

    vecs[0]  = '{1'b1, 1'b1, 7'd0,  32'h0000_03FF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 7'd0,  32'h0,         32'h0000_03FF};
    vecs[2]  = '{1'b1, 1'b1, 7'd15, 32'hFFFF_F555, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 7'd15, 32'h0,         32'h0000_0155};
    vecs[4]  = '{1'b1, 1'b0, 7'd14, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 1'b1, 7'h20, 32'h0000_0077, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 7'h20, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 7'h7F, 32'h0,         32'h0};
    vecs[8]  = '{1'b0, 1'b0, 7'd0,  32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b0, 7'h40, 32'h0,         32'h0000_0002};
    vecs[10] = '{1'b0, 1'b1, 7'd2,  32'h0000_0155, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 7'd2,  32'h0,         32'h0};

    reset = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    vblank = 1'b0; rd_req = 1'b0; rd_idx = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rd_ack", 32'(rd_ack), 32'd0);
    check("reset_rd_xy", {12'b0, rd_x, rd_y}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    cpu_read(7'h40, d);
    check("reset_status", d, 32'd0);

    // Table of CPU accesses
    for (int i = 0; i < 12; i++) begin
      cpu_en = vecs[i].en; cpu_we = vecs[i].we;
      cpu_adr = {23'b0, vecs[i].off, 2'b00}; cpu_wdata = vecs[i].wdata;
      #1;
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp);
      @(negedge clk);
      cpu_en = 1'b0; cpu_we = 1'b0;
    end

    // Basic commit
    cpu_write(7'd6, 32'h123);
    vblank_commit(c);
    exp_frames++;
    check("basic_busy_cycles", 32'(c), 32'd8);
    render_read(3, x, y);
    check("basic_e3_xy", {12'b0, x, y}, {12'b0, 10'h123, 10'h0});
    render_read(0, x, y);
    check("basic_e0_x", 32'(x), 32'h3FF);
    render_read(7, x, y);
    check("basic_e7_y", 32'(y), 32'h155);
    cpu_read(7'h40, d);
    check("basic_status", d, status_exp(1'b0, 1'b0));

    // Tear protection
    cpu_write(7'd0, 32'd50);
    repeat (4) @(negedge clk);
    render_read(0, x, y);
    check("tear_e0_x_a", 32'(x), 32'h3FF);
    cpu_read(7'h40, d);
    check("tear_status_dirty", d, status_exp(1'b0, 1'b1));
    repeat (6) @(negedge clk);
    render_read(0, x, y);
    check("tear_e0_x_b", 32'(x), 32'h3FF);
    vblank_commit(c);
    exp_frames++;
    check("tear_busy_cycles", 32'(c), 32'd8);
    render_read(0, x, y);
    check("tear_e0_x_after", 32'(x), 32'd50);

    // Read stall during commit
    cpu_write(7'd10, 32'h2AA);
    cpu_write(7'd11, 32'h0AB);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_busy_at_req", 32'(busy), 32'd1);
    rd_req = 1'b1; rd_idx = 3'd5;
    fall_k = -1; ack_k = -1; ack_cnt = 0; ack_x = '0; ack_y = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) rd_req = 1'b0;
      if (!busy && fall_k < 0) fall_k = k;
      if (rd_ack) begin
        ack_cnt++;
        if (ack_k < 0) begin
          ack_k = k; ack_x = rd_x; ack_y = rd_y;
        end
      end
    end
    vblank = 1'b0;
    exp_frames++;
    check("stall_busy_fall_k", 32'(fall_k), 32'd6);
    check("stall_ack_k", 32'(ack_k), 32'(fall_k + 1));
    check("stall_ack_count", 32'(ack_cnt), 32'd1);
    check("stall_ack_xy", {12'b0, ack_x, ack_y}, {12'b0, 10'h2AA, 10'h0AB});
    check("stall_hold_xy", {12'b0, rd_x, rd_y}, {12'b0, 10'h2AA, 10'h0AB});

    // Stores during commit: entry 7 at ptr=2, entry 1 at ptr=4
    cpu_write(7'd12, 32'h011);
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    cpu_write(7'd14, 32'h1C7);
    @(negedge clk);
    cpu_write(7'd2, 32'h0F0);
    wait_idle(c);
    vblank = 1'b0;
    exp_frames++;
    check("sdc_end_busy", 32'(busy), 32'd0);
    render_read(7, x, y);
    check("sdc_e7_x", 32'(x), 32'h1C7);
    render_read(1, x, y);
    check("sdc_e1_x_old", 32'(x), 32'h0);
    render_read(6, x, y);
    check("sdc_e6_x", 32'(x), 32'h011);
    cpu_read(7'h40, d);
    check("sdc_status_armed", d, status_exp(1'b0, 1'b1));
    vblank_commit(c);
    exp_frames++;
    check("sdc_busy_cycles", 32'(c), 32'd8);
    render_read(1, x, y);
    check("sdc_e1_x_new", 32'(x), 32'h0F0);

    // Reset mid-commit
    render_read(7, x, y);
    check("pre_reset_e7_x", 32'(x), 32'h1C7);
    cpu_write(7'h41, 32'h1);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_xy", {12'b0, rd_x, rd_y}, 32'd0);
    check("abort_rd_ack", 32'(rd_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    cpu_read(7'h40, d);
    check("abort_status", d, 32'd0);
    for (int i = 0; i < 8; i++) begin
      render_read(i, x, y);
      check($sformatf("abort_live%0d", i), {12'b0, x, y}, 32'd0);
    end
    cpu_read(7'd14, d);
    check("abort_shadow_e7_x", d, 32'd0);

    // Forced commits and frame counter
    cpu_write(7'h41, 32'h0);
    c = 0;
    for (int k = 0; k < 3; k++) begin
      if (busy) c++;
      @(negedge clk);
    end
    check("ctrl_zero_no_commit", 32'(c), 32'd0);
    for (int n = 0; n < 3; n++) begin
      cpu_write(7'h41, 32'h1);
      check($sformatf("force%0d_started", n), 32'(busy), 32'd1);
      wait_idle(c);
      exp_frames++;
      check($sformatf("force%0d_busy_cycles", n), 32'(c), 32'd8);
      @(negedge clk);
    end
    cpu_read(7'h40, d);
    check("force_status_frames", d, status_exp(1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
